// File: rtl/trade_order_emitter.sv
// trade_order_emitter: gates completed optimizer results into an order FIFO and
// serializes each order as a 5-beat 32-bit AXI4-Stream packet with saturating stats.
module trade_order_emitter #(
  parameter int          PRICE_WIDTH = 48,
  parameter int          QTY_WIDTH   = 32,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          optimization_complete,
  input  logic                          trade_signal_valid,
  input  logic [PRICE_WIDTH-1:0]        optimal_entry_price,
  input  logic [PRICE_WIDTH-1:0]        optimal_exit_price,
  input  logic [QTY_WIDTH-1:0]          optimal_quantity,
  input  logic [1:0]                    optimal_base_used,
  input  logic [15:0]                   confidence_score,
  input  logic [15:0]                   min_confidence,
  input  logic [31:0]                   risk_limit,
  input  logic [7:0]                    strategy_id,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [31:0]                   orders_sent,
  output logic [31:0]                   orders_rejected,
  output logic [31:0]                   orders_dropped,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, B4} state_t;

  typedef struct packed {
    logic [7:0]             strat;
    logic [7:0]             seq;
    logic [1:0]             base;
    logic [PRICE_WIDTH-1:0] entry_px;
    logic [PRICE_WIDTH-1:0] exit_px;
    logic [QTY_WIDTH-1:0]   qty;
  } order_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  state_t            state_q, state_d;
  order_t            sh_q, sh_d;
  order_t            mem_q [FIFO_DEPTH];
  order_t            new_order;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic [7:0]        seq_q, seq_d;
  logic              prev_q;
  logic [31:0]       sent_q, sent_d, rej_q, rej_d, drop_q, drop_d;
  logic              evt, qual, empty, full, push, pop, hs;

  always_comb begin
    evt       = optimization_complete & ~prev_q & enable & trade_signal_valid;
    qual      = (optimal_quantity != '0) && (optimal_quantity <= risk_limit) &&
                (confidence_score >= min_confidence);
    empty     = level_q == '0;
    full      = level_q == LW'(FIFO_DEPTH);
    push      = evt & qual & ~full;
    m_axis_tvalid = state_q != IDLE;
    m_axis_tlast  = state_q == B4;
    hs        = m_axis_tvalid & m_axis_tready;
    pop       = ~empty & ((state_q == IDLE) | (state_q == B4 & hs));
    new_order = '{strat: strategy_id, seq: seq_q, base: optimal_base_used,
                  entry_px: optimal_entry_price, exit_px: optimal_exit_price,
                  qty: optimal_quantity};
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    level_d   = level_q + LW'(push) - LW'(pop);
    seq_d     = seq_q + 8'(push);
    sh_d      = pop ? mem_q[rd_q] : sh_q;
    sent_d    = sat_inc(sent_q, state_q == B4 & hs);
    rej_d     = sat_inc(rej_q, evt & ~qual);
    drop_d    = sat_inc(drop_q, evt & qual & full);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : B0;
      B0:      state_d = hs ? B1 : B0;
      B1:      state_d = hs ? B2 : B1;
      B2:      state_d = hs ? B3 : B2;
      B3:      state_d = hs ? B4 : B3;
      B4:      state_d = !hs ? B4 : (empty ? IDLE : B0);
      default: state_d = IDLE;
    endcase
    m_axis_tdata = state_q == B0 ? {SYNC_BYTE, sh_q.strat, sh_q.seq, 6'd0, sh_q.base} :
                   state_q == B1 ? {sh_q.entry_px[47:32], sh_q.exit_px[47:32]} :
                   state_q == B2 ? sh_q.entry_px[31:0] :
                   state_q == B3 ? sh_q.exit_px[31:0] :
                   state_q == B4 ? sh_q.qty : 32'd0;
  end

  // queue storage carries no reset; validity is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= new_order;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      seq_q   <= '0;
      prev_q  <= 1'b0;
      sent_q  <= '0;
      rej_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      seq_q   <= seq_d;
      prev_q  <= optimization_complete;
      sent_q  <= sent_d;
      rej_q   <= rej_d;
      drop_q  <= drop_d;
    end
  end

  assign orders_sent     = sent_q;
  assign orders_rejected = rej_q;
  assign orders_dropped  = drop_q;
  assign fifo_level      = level_q;
  assign busy            = (state_q != IDLE) | (level_q != '0);
endmodule

// File: tb/tb_trade_order_emitter.sv
// tb_trade_order_emitter: directed scenario tasks with hand-computed packet beats.
module tb_trade_order_emitter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b1, optimization_complete = 1'b0, trade_signal_valid = 1'b1;
  logic [47:0] optimal_entry_price = 48'h0001_0000_1234;
  logic [47:0] optimal_exit_price  = 48'h0001_0000_5678;
  logic [31:0] optimal_quantity = 32'd500;
  logic [1:0]  optimal_base_used = 2'd2;
  logic [15:0] confidence_score = 16'd200, min_confidence = 16'd100;
  logic [31:0] risk_limit = 32'd1000;
  logic [7:0]  strategy_id = 8'd7;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
  logic [31:0] orders_sent, orders_rejected, orders_dropped;
  logic [2:0]  fifo_level;
  logic        busy;

  int          passed = 0, total = 0;
  logic [31:0] pkt [5];
  logic        lst [5];
  int          got, cyc;
  logic        saw_v;

  trade_order_emitter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .optimization_complete(optimization_complete), .trade_signal_valid(trade_signal_valid),
    .optimal_entry_price(optimal_entry_price), .optimal_exit_price(optimal_exit_price),
    .optimal_quantity(optimal_quantity), .optimal_base_used(optimal_base_used),
    .confidence_score(confidence_score), .min_confidence(min_confidence),
    .risk_limit(risk_limit), .strategy_id(strategy_id),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .orders_sent(orders_sent), .orders_rejected(orders_rejected),
    .orders_dropped(orders_dropped), .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic fire();
    @(negedge clk); optimization_complete = 1'b1;
    @(negedge clk); optimization_complete = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin saw_v |= m_axis_tvalid; @(negedge clk); end
  endtask

  task automatic collect(input int n, input int max);
    got = 0; cyc = 0;
    while (got < n && cyc < max) begin
      if (m_axis_tvalid && m_axis_tready) begin
        pkt[got] = m_axis_tdata; lst[got] = m_axis_tlast; got++;
      end
      cyc++; @(negedge clk);
    end
    total++;
    if (got != n) $display("FAIL collect_timeout: got %0d beats, expected %0d", got, n); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); else passed++;
    total++; if (m_axis_tdata !== 32'd0) $display("FAIL rst_tdata: got %h expected 0", m_axis_tdata); else passed++;
    total++; if ({orders_sent, orders_rejected, orders_dropped} !== 96'd0) $display("FAIL rst_counters: got %h expected 0", {orders_sent, orders_rejected, orders_dropped}); else passed++;
    total++; if ({fifo_level, busy, m_axis_tlast} !== 5'd0) $display("FAIL rst_level_busy: got %b expected 0", {fifo_level, busy, m_axis_tlast}); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] exp [5];
    exp = '{32'hA507_0002, 32'h0001_0001, 32'h0000_1234, 32'h0000_5678, 32'h0000_01F4};
    fire();
    total++; if (m_axis_tvalid !== 1'b0) $display("FAIL lat_early: got %b expected 0", m_axis_tvalid); else passed++;
    @(negedge clk);
    total++; if (m_axis_tvalid !== 1'b1) $display("FAIL lat_rise: got %b expected 1", m_axis_tvalid); else passed++;
    collect(5, 20);
    for (int i = 0; i < 5; i++) begin
      total++; if (pkt[i] !== exp[i]) $display("FAIL single_beat%0d: got %h expected %h", i, pkt[i], exp[i]); else passed++;
    end
    total++; if ({lst[0], lst[1], lst[2], lst[3], lst[4]} !== 5'b00001) $display("FAIL single_tlast: got %b expected 00001", {lst[0], lst[1], lst[2], lst[3], lst[4]}); else passed++;
    total++; if (orders_sent !== 32'd1) $display("FAIL single_sent: got %0d expected 1", orders_sent); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_gating();
    saw_v = 1'b0;
    optimal_quantity = 32'd2000; fire(); idle(4);
    total++; if (orders_rejected !== 32'd1) $display("FAIL gate_qty: got %0d expected 1", orders_rejected); else passed++;
    optimal_quantity = 32'd500; confidence_score = 16'd50; fire(); idle(4);
    total++; if (orders_rejected !== 32'd2) $display("FAIL gate_conf: got %0d expected 2", orders_rejected); else passed++;
    confidence_score = 16'd200; trade_signal_valid = 1'b0; fire(); idle(4);
    total++; if (orders_rejected !== 32'd2) $display("FAIL gate_tsv: got %0d expected 2", orders_rejected); else passed++;
    trade_signal_valid = 1'b1; enable = 1'b0; fire(); idle(4);
    total++; if ({orders_rejected, orders_sent, 29'd0, fifo_level} !== {32'd2, 32'd1, 32'd0}) $display("FAIL gate_enable: got rej %0d sent %0d lvl %0d expected 2 1 0", orders_rejected, orders_sent, fifo_level); else passed++;
    enable = 1'b1; optimal_quantity = 32'd0; fire(); idle(4);
    total++; if (orders_rejected !== 32'd3) $display("FAIL gate_qty0: got %0d expected 3", orders_rejected); else passed++;
    total++; if (saw_v !== 1'b0) $display("FAIL gate_no_tvalid: got %b expected 0", saw_v); else passed++;
    optimal_quantity = 32'd500;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    optimal_quantity = 32'd1000; confidence_score = 16'd100;
    fire(); @(negedge clk);
    total++; if (m_axis_tdata !== 32'hA507_0102) $display("FAIL bp_b0: got %h expected A5070102", m_axis_tdata); else passed++;
    @(negedge clk); @(negedge clk);
    m_axis_tready = 1'b0;
    held = m_axis_tdata;
    total++; if (held !== 32'h0000_1234) $display("FAIL bp_b2: got %h expected 00001234", held); else passed++;
    repeat (3) begin
      @(negedge clk);
      total++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, 32'h0000_1234}) $display("FAIL bp_hold: got v%b l%b %h expected v1 l0 00001234", m_axis_tvalid, m_axis_tlast, m_axis_tdata); else passed++;
    end
    m_axis_tready = 1'b1;
    collect(3, 20);
    total++; if ({pkt[0], pkt[1], pkt[2]} !== {32'h0000_1234, 32'h0000_5678, 32'h0000_03E8}) $display("FAIL bp_tail: got %h %h %h expected 00001234 00005678 000003E8", pkt[0], pkt[1], pkt[2]); else passed++;
    total++; if ({lst[0], lst[1], lst[2], orders_sent} !== {3'b001, 32'd2}) $display("FAIL bp_done: got tlast %b%b%b sent %0d expected 001 2", lst[0], lst[1], lst[2], orders_sent); else passed++;
    optimal_quantity = 32'd500; confidence_score = 16'd200;
  endtask

  task automatic test_overflow();
    int sum;
    m_axis_tready = 1'b0;
    repeat (6) fire();
    total++; if (orders_dropped !== 32'd1) $display("FAIL ovf_dropped: got %0d expected 1", orders_dropped); else passed++;
    total++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d expected 4", fifo_level); else passed++;
    total++; if ({m_axis_tvalid, busy, m_axis_tdata} !== {2'b11, 32'hA507_0202}) $display("FAIL ovf_shadow: got v%b b%b %h expected v1 b1 A5070202", m_axis_tvalid, busy, m_axis_tdata); else passed++;
    m_axis_tready = 1'b1;
    sum = 0;
    for (int p = 0; p < 5; p++) begin
      collect(5, 10);
      sum += cyc;
      total++; if ({pkt[0], lst[4]} !== {8'hA5, 8'h07, 8'(p + 2), 8'h02, 1'b1}) $display("FAIL ovf_pkt%0d: got %h tlast %b expected seq %0d", p, pkt[0], lst[4], p + 2); else passed++;
    end
    total++; if (sum !== 25) $display("FAIL ovf_back_to_back: got %0d cycles expected 25", sum); else passed++;
    total++; if ({orders_sent, 29'd0, fifo_level} !== {32'd7, 32'd0}) $display("FAIL ovf_sent: got sent %0d lvl %0d expected 7 0", orders_sent, fifo_level); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq, prev;
    int bad;
    logic wrapped;
    exp_seq = 8'd7; prev = 8'd0; bad = 0; wrapped = 1'b0;
    for (int n = 0; n < 257; n++) begin
      fire();
      collect(5, 20);
      if (pkt[0][15:8] != exp_seq) bad++;
      if (n > 0 && prev == 8'd255 && pkt[0][15:8] == 8'd0) wrapped = 1'b1;
      prev = pkt[0][15:8];
      exp_seq++;
    end
    total++; if (bad !== 0) $display("FAIL wrap_seq: got %0d wrong seq fields expected 0", bad); else passed++;
    total++; if (wrapped !== 1'b1) $display("FAIL wrap_255_0: got %b expected 1", wrapped); else passed++;
    total++; if ({orders_sent, orders_dropped} !== {32'd264, 32'd1}) $display("FAIL wrap_counts: got sent %0d dropped %0d expected 264 1", orders_sent, orders_dropped); else passed++;
  endtask

  task automatic test_reset_mid();
    fire(); @(negedge clk); @(negedge clk); @(negedge clk);
    total++; if (m_axis_tdata !== 32'h0000_1234) $display("FAIL rm_b2: got %h expected 00001234", m_axis_tdata); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rm_tvalid: got %b expected 0", m_axis_tvalid); else passed++;
    total++; if ({orders_sent, orders_rejected, orders_dropped, 29'd0, fifo_level} !== 128'd0) $display("FAIL rm_counters: got sent %0d rej %0d drop %0d lvl %0d expected 0", orders_sent, orders_rejected, orders_dropped, fifo_level); else passed++;
    @(negedge clk); rst_n = 1'b1;
    fire();
    collect(5, 20);
    total++; if ({pkt[0], lst[4]} !== {32'hA507_0002, 1'b1}) $display("FAIL rm_after: got %h tlast %b expected A5070002 1", pkt[0], lst[4]); else passed++;
    total++; if (orders_sent !== 32'd1) $display("FAIL rm_sent: got %0d expected 1", orders_sent); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_gating();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
